// File: rtl/mdu_pkg.sv
// Shared types for the iterative RISC-V M-extension unit: FSM states,
// Funct3 opcodes and operand signedness decode.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic src_a_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic src_b_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

  // Signed divides are the only ops that can hit the MIN / -1 overflow case.
  function automatic logic is_signed_div(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_DIV, F3_REM: s = 1'b1;
      default:        s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_controller.sv
// Iterative multiply/divide unit: one shift-add or restore step per cycle on
// operand magnitudes, with sign correction in a single FIX cycle.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Kill,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  mdu_state_e state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg_s, b_neg_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic              div_zero_s, div_ovf_s;
  logic [XLEN-1:0]   bypass_res_s;

  // Operand decode at acceptance time: magnitudes and special divide cases.
  always_comb begin
    a_neg_s    = src_a_signed(Funct3) & SrcA[XLEN-1];
    b_neg_s    = src_b_signed(Funct3) & SrcB[XLEN-1];
    mag_a_s    = a_neg_s ? (~SrcA + {{(XLEN-1){1'b0}}, 1'b1}) : SrcA;
    mag_b_s    = b_neg_s ? (~SrcB + {{(XLEN-1){1'b0}}, 1'b1}) : SrcB;
    div_zero_s = (SrcB == {XLEN{1'b0}});
    div_ovf_s  = is_signed_div(Funct3) &&
                 (SrcA == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (SrcB == {XLEN{1'b1}});
    if (div_zero_s) begin
      bypass_res_s = Funct3[1] ? SrcA : {XLEN{1'b1}};
    end else begin
      bypass_res_s = Funct3[1] ? {XLEN{1'b0}} : SrcA;
    end
  end

  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] div_next_s;

  // One iteration: acc holds {partial, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_q[XLEN-1:1]};
    div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    if (div_diff_s[XLEN]) begin
      div_next_s = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_res_s;

  // Sign correction and result selection used in the FIX cycle.
  always_comb begin
    prod_fix_s = neg_res_q ? (~acc_q + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_q;
    quo_fix_s  = neg_res_q ? (~acc_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                           : acc_q[XLEN-1:0];
    rem_fix_s  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                           : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                       fix_res_s = prod_fix_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res_s = quo_fix_s;
      F3_REM, F3_REMU:              fix_res_s = rem_fix_s;
      default:                      fix_res_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (Kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            op_d      = Funct3;
            neg_res_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            cnt_d     = {CW{1'b0}};
            opnd_d    = Funct3[2] ? mag_b_s : mag_a_s;
            acc_d     = {{XLEN{1'b0}}, (Funct3[2] ? mag_a_s : mag_b_s)};
            if (Funct3[2] && (div_zero_s || div_ovf_s)) begin
              result_d = bypass_res_s;
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          acc_d = op_q[2] ? div_next_s : mul_next_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_ITER) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
        FIX: begin
          result_d = fix_res_s;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= 3'b000;
      opnd_q    <= {XLEN{1'b0}};
      acc_q     <= {(2*XLEN){1'b0}};
      cnt_q     <= {CW{1'b0}};
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: doc/mdu_controller.md
MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand/result width in bits.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 The module SHALL have port Start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 The module SHALL have port Funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The module SHALL have port SrcA  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-007 The module SHALL have port SrcB  input  XLEN  rs2 operand (multiplier/divisor).
REQ-008 The module SHALL have port Kill  input  1  pipeline flush; aborts any operation.
REQ-009 The module SHALL have port Busy  output  1  high while an accepted operation is in progress; the pipeline stalls on it.
REQ-010 The module SHALL have port Done  output  1  one-cycle pulse; Result is valid in that cycle.
REQ-011 The module SHALL have port Result  output  XLEN  result of the last completed operation.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-013 The FSM SHALL accept Start=1 with Kill=0 in IDLE or DONE (cycle 0), latching Funct3, SrcA and SrcB; later input changes SHALL be ignored.
REQ-014 Start SHALL be ignored while in CALC or FIX.
REQ-015 Normal path: CALC SHALL occupy cycles 1..XLEN (one iteration per cycle), FIX cycle XLEN+1, and DONE cycle XLEN+2, in which Done=1.
REQ-016 Busy SHALL be 1 exactly in CALC and FIX, and 0 in IDLE and DONE.
REQ-017 DONE SHALL last one cycle, then go to IDLE, or to CALC if a new Start is accepted (back-to-back).
REQ-018 Multiply SHALL be an unsigned shift-add on operand magnitudes into a 2*XLEN product; signedness: MULH both operands signed, MULHSU SrcA signed, MULHU and MUL unsigned.
REQ-019 In FIX, the multiply SHALL negate the product if the operand signs differ; MUL returns the low XLEN bits, and MULH/MULHSU/MULHU return the high XLEN bits.
REQ-020 Divide SHALL be a restoring divide on magnitudes; in FIX, the quotient is negated if the signs differ (DIV) and the remainder takes the sign of the dividend (REM).
REQ-021 Divide-by-zero (SrcB=0) SHALL bypass CALC/FIX and go IDLE->DONE, with Done in cycle 1: DIV/DIVU return all ones and REM/REMU return SrcA.
REQ-022 Signed overflow (DIV/REM, SrcA=100..0, SrcB=all ones) SHALL also bypass to DONE in cycle 1: DIV returns 100..0 and REM returns 0.
REQ-023 Result SHALL update only on entry to DONE and hold until the next DONE.
REQ-024 Kill=1 in any state SHALL force IDLE on the next edge, with no Done and Result unchanged; Kill SHALL win over a simultaneous Start.

Reset
REQ-025 On reset=1 at a clk edge, the state SHALL become IDLE, with Busy=0, Done=0, Result=0 and all operand, accumulator and iteration-counter registers=0.
REQ-026 Reset mid-operation SHALL abort without a Done pulse; reset SHALL take priority over Start and Kill.

Structure
REQ-027 A shared package mdu_pkg SHALL hold the FSM state enum (IDLE, CALC, FIX, DONE) and the Funct3 opcode localparams for the eight M ops.
REQ-028 No sub-module SHALL be used; the iteration counter ($clog2(XLEN)+1 bits), shift/add and restore steps SHALL be inline in mdu_controller.

Verification
REQ-029 The bench SHALL check: MUL SrcA=7, SrcB=0xFFFFFFF9 (-7) -> Result 0xFFFFFFCF with Done only in cycle 34, and Busy=1 in cycles 1..33.
REQ-030 The bench SHALL check: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000.
REQ-031 The bench SHALL check: DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 20/3 -> 6.
REQ-032 The bench SHALL check: DIVU 5/0 -> 0xFFFFFFFF with Done in cycle 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-033 The bench SHALL check: Kill in cycle 10 of a MUL -> IDLE in cycle 11, Busy=0, no Done, and Result still equal to the prior value.
REQ-034 The bench SHALL check: Start asserted in cycle 5 of an operation is ignored; Start in the DONE cycle is accepted and its Done arrives 34 cycles later.
